// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed 7-segment scan controller. A shadow buffer collects a full
// frame of digits (nibble, decimal point, blank) and is copied into the
// active buffer only at a frame boundary, so the display never tears.
// A prescaler paces the digit slots and a free-running 4-bit PWM counter
// gates the anode of the selected digit for brightness control.
// All outputs are registered: state at cycle t is visible at t+1.

module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int ANODE_W    = 8,
    parameter int TICK_DIV   = 400000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK_IN,
    input  logic [3:0]              BRIGHT,
    output logic [3:0]              DIGIT_OUT,
    output logic                    DP_OUT,
    output logic [ANODE_W-1:0]      ANODE,
    output logic [2:0]              DIGIT_IDX,
    output logic                    FRAME_DONE
);

    // Prescaler width follows TICK_DIV; guard keeps it at least one bit wide.
    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   P_MAX   = PW'(TICK_DIV - 1);
    localparam logic [2:0]      IDX_MAX = 3'(NUM_DIGITS - 1);

    // Counters
    logic [PW-1:0]             p_r;
    logic [2:0]                idx_r;
    logic [3:0]                q_r;

    // Double buffer
    logic [4*NUM_DIGITS-1:0]   shadow_data_r;
    logic [NUM_DIGITS-1:0]     shadow_dp_r;
    logic [NUM_DIGITS-1:0]     shadow_blank_r;
    logic [4*NUM_DIGITS-1:0]   active_data_r;
    logic [NUM_DIGITS-1:0]     active_dp_r;
    logic [NUM_DIGITS-1:0]     active_blank_r;

    // Marks the first cycle showing freshly swapped active contents
    logic                      frame_pend_r;

    // Combinational helpers
    logic                      tick_s;
    logic                      frame_s;
    logic [2:0]                idx_next_s;
    logic                      lit_s;
    logic                      hit_s;
    logic [3:0]                sel_data_s;
    logic                      sel_dp_s;
    logic [ANODE_W-1:0]        anode_s;

    assign tick_s  = (p_r == P_MAX);
    assign frame_s = tick_s && (idx_r == IDX_MAX);

    // Next scan index: advance on tick, wrapping after the last digit.
    always_comb begin
        idx_next_s = idx_r;
        if (tick_s) begin
            if (idx_r == IDX_MAX) begin
                idx_next_s = 3'd0;
            end else begin
                idx_next_s = idx_r + 3'd1;
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Prescaler, scan index and free-running PWM counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_r   <= '0;
            idx_r <= 3'd0;
            q_r   <= 4'd0;
        end else begin
            p_r   <= tick_s ? '0 : (p_r + PW'(1));
            idx_r <= idx_next_s;
            q_r   <= q_r + 4'd1;
        end
    end

    // Shadow capture on LOAD; active takes the pre-LOAD shadow at a frame boundary.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shadow_data_r  <= '0;
            shadow_dp_r    <= '0;
            shadow_blank_r <= '1;
            active_data_r  <= '0;
            active_dp_r    <= '0;
            active_blank_r <= '1;
            frame_pend_r   <= 1'b0;
        end else begin
            if (LOAD) begin
                shadow_data_r  <= DATA_IN;
                shadow_dp_r    <= DP_IN;
                shadow_blank_r <= BLANK_IN;
            end
            if (frame_s) begin
                active_data_r  <= shadow_data_r;
                active_dp_r    <= shadow_dp_r;
                active_blank_r <= shadow_blank_r;
            end
            frame_pend_r <= frame_s;
        end
    end

    // Select the current digit (AND-OR mux) and build the active-low anode word.
    always_comb begin
        sel_data_s = 4'h0;
        sel_dp_s   = 1'b0;
        hit_s      = 1'b0;
        anode_s    = '1;
        lit_s      = ENABLE && (q_r <= BRIGHT);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hit_s      = (idx_r == 3'(k));
            sel_data_s = sel_data_s | (active_data_r[4*k +: 4] & {4{hit_s}});
            sel_dp_s   = sel_dp_s | (active_dp_r[k] & hit_s);
            anode_s[k] = ~(lit_s & hit_s & ~active_blank_r[k]);
        end
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ANODE      <= '1;
            DIGIT_OUT  <= 4'h0;
            DP_OUT     <= 1'b0;
            DIGIT_IDX  <= 3'd0;
            FRAME_DONE <= 1'b0;
        end else begin
            ANODE      <= anode_s;
            DIGIT_OUT  <= sel_data_s;
            DP_OUT     <= sel_dp_s;
            DIGIT_IDX  <= idx_r;
            FRAME_DONE <= frame_pend_r;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: 4 digits, 8-bit anode bus. One instance with
// TICK_DIV=4 for scan/buffer behaviour, one with TICK_DIV=64 for PWM duty.
// Cycle c counts rising edges since reset release; outputs sampled 1 time
// unit after edge c reflect the state after edge c-1.

module tb_seg_scan_ctrl;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        LOAD;
    logic [15:0] DATA_IN;
    logic [3:0]  DP_IN;
    logic [3:0]  BLANK_IN;
    logic [3:0]  BRIGHT;

    logic [3:0]  DIGIT_OUT;
    logic        DP_OUT;
    logic [7:0]  ANODE;
    logic [2:0]  DIGIT_IDX;
    logic        FRAME_DONE;

    logic [3:0]  digit_out64;
    logic        dp_out64;
    logic [7:0]  anode64;
    logic [2:0]  digit_idx64;
    logic        frame_done64;

    int tests;
    int fails;
    int cyc;

    seg_scan_ctrl #(.NUM_DIGITS(4), .ANODE_W(8), .TICK_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD),
        .DATA_IN(DATA_IN), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN), .BRIGHT(BRIGHT),
        .DIGIT_OUT(DIGIT_OUT), .DP_OUT(DP_OUT), .ANODE(ANODE),
        .DIGIT_IDX(DIGIT_IDX), .FRAME_DONE(FRAME_DONE)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .ANODE_W(8), .TICK_DIV(64)) dut64 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD),
        .DATA_IN(DATA_IN), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN), .BRIGHT(BRIGHT),
        .DIGIT_OUT(digit_out64), .DP_OUT(dp_out64), .ANODE(anode64),
        .DIGIT_IDX(digit_idx64), .FRAME_DONE(frame_done64)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [31:0] exp_anode;   // {slot3, slot2, slot1, slot0}
        logic [15:0] exp_digit;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // o = offset from the first cycle of a frame (FRAME_DONE cycle).
    task automatic check_cycle(input logic [31:0] an4, input logic [15:0] dg4,
                               input logic [3:0] dp4, input int o, input bit fd_en);
        int slot;
        slot = (o / 4) % 4;
        chk("anode", 32'(ANODE), 32'(an4[slot*8 +: 8]));
        chk("digit_out", 32'(DIGIT_OUT), 32'(dg4[slot*4 +: 4]));
        chk("dp_out", 32'(DP_OUT), 32'(dp4[slot]));
        chk("digit_idx", 32'(DIGIT_IDX), 32'(slot));
        chk("frame_done", 32'(FRAME_DONE), 32'(fd_en && ((o % 16) == 0)));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_anode"}, 32'(ANODE), 32'h0000_00FF);
        chk({tag, "_digit"}, 32'(DIGIT_OUT), 32'h0);
        chk({tag, "_dp"}, 32'(DP_OUT), 32'h0);
        chk({tag, "_idx"}, 32'(DIGIT_IDX), 32'h0);
        chk({tag, "_fd"}, 32'(FRAME_DONE), 32'h0);
    endtask

    // Right after reset release with nothing loaded: dark, digit 0, scan 0..3.
    task automatic run_dark(input int n);
        for (int c = 1; c <= n; c++) begin
            step();
            check_cycle(32'hFFFF_FFFF, 16'h0000, 4'h0, c - 1, c >= 17);
        end
    endtask

    logic [31:0] prev_an;
    logic [15:0] prev_dg;
    logic [3:0]  prev_dp;
    logic [7:0]  an_exp;
    int          cnt;

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;

        vecs[0] = '{16'h4321, 4'b0100, 4'b0000, 32'hF7FB_FDFE, 16'h4321, 4'b0100};
        vecs[1] = '{16'h8765, 4'b0001, 4'b1010, 32'hFFFB_FFFE, 16'h8765, 4'b0001};
        vecs[2] = '{16'h0F9C, 4'b1111, 4'b1111, 32'hFFFF_FFFF, 16'h0F9C, 4'b1111};
        vecs[3] = '{16'hBEEF, 4'b1001, 4'b0110, 32'hF7FF_FFFE, 16'hBEEF, 4'b1001};

        RESET    = 1'b1;
        ENABLE   = 1'b1;
        LOAD     = 1'b0;
        DATA_IN  = 16'h0000;
        DP_IN    = 4'h0;
        BLANK_IN = 4'h0;
        BRIGHT   = 4'd15;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("in_reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc   = 0;
        check_reset_outputs("released");

        // Three frames dark, FRAME_DONE every 16 cycles from cycle 17.
        run_dark(48);

        // Table-driven frames: previous contents until FRAME_DONE, then new.
        prev_an = 32'hFFFF_FFFF;
        prev_dg = 16'h0000;
        prev_dp = 4'h0;
        for (int i = 0; i < 4; i++) begin
            DATA_IN  = vecs[i].data;
            DP_IN    = vecs[i].dp;
            BLANK_IN = vecs[i].blank;
            LOAD     = 1'b1;
            step();
            check_cycle(prev_an, prev_dg, prev_dp, 0, 1'b1);
            LOAD     = 1'b0;
            DATA_IN  = ~vecs[i].data;
            DP_IN    = ~vecs[i].dp;
            BLANK_IN = ~vecs[i].blank;
            for (int o = 1; o < 16; o++) begin
                step();
                check_cycle(prev_an, prev_dg, prev_dp, o, 1'b1);
            end
            for (int o = 0; o < 16; o++) begin
                step();
                check_cycle(vecs[i].exp_anode, vecs[i].exp_digit, vecs[i].exp_dp, o, 1'b1);
            end
            prev_an = vecs[i].exp_anode;
            prev_dg = vecs[i].exp_digit;
            prev_dp = vecs[i].exp_dp;
        end

        // LOAD exactly on the frame-boundary edge (edge 192).
        for (int o = 0; o < 15; o++) begin
            step();
            check_cycle(prev_an, prev_dg, prev_dp, o, 1'b1);
        end
        DATA_IN  = 16'hAAAA;
        DP_IN    = 4'h0;
        BLANK_IN = 4'h0;
        LOAD     = 1'b1;
        step();
        check_cycle(prev_an, prev_dg, prev_dp, 15, 1'b1);
        LOAD     = 1'b0;
        DATA_IN  = 16'h5555;
        BLANK_IN = 4'hF;
        for (int o = 0; o < 16; o++) begin
            step();
            check_cycle(prev_an, prev_dg, prev_dp, o, 1'b1);
        end
        for (int o = 0; o < 16; o++) begin
            step();
            check_cycle(32'hF7FB_FDFE, 16'hAAAA, 4'h0, o, 1'b1);
        end

        // ENABLE=0 darkens on the next edge; digits keep scanning.
        ENABLE = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("enable_off_anode", 32'(ANODE), 32'h0000_00FF);
            chk("enable_off_digit", 32'(DIGIT_OUT), 32'h0000_000A);
        end
        ENABLE = 1'b1;
        step();
        an_exp = 8'hFF;
        an_exp[((cyc - 1) / 4) % 4] = 1'b0;
        chk("enable_on_anode", 32'(ANODE), 32'(an_exp));

        // PWM duty on the TICK_DIV=64 instance: lit cycles per 16-cycle window.
        BRIGHT = 4'd3;
        while (cyc < 272) step();
        for (int w = 0; w < 16; w++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                step();
                if (anode64 != 8'hFF) cnt++;
            end
            chk("pwm_bright3", 32'(cnt), 32'd4);
        end
        BRIGHT = 4'd0;
        for (int w = 0; w < 8; w++) begin
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                step();
                if (anode64 != 8'hFF) cnt++;
            end
            chk("pwm_bright0", 32'(cnt), 32'd1);
        end
        BRIGHT = 4'd15;

        // Reset mid-frame with a pending LOAD: outputs clear at once, data lost.
        DATA_IN  = 16'h1357;
        DP_IN    = 4'hF;
        BLANK_IN = 4'h0;
        LOAD     = 1'b1;
        step();
        LOAD     = 1'b0;
        step();
        step();
        chk("pre_reset_digit", 32'(DIGIT_OUT), 32'h0000_000A);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc   = 0;
        run_dark(48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
